// File: rtl/exp_golomb_decoder.sv
// Exp-Golomb syntax-element decoder, ue(v) / se(v) / te(v) with cMax = 1.
// Reads an MSB-first window from the bitstream buffer and reports how many
// bits to consume each cycle. Prefixes and suffixes longer than the window
// are walked over several cycles.
module exp_golomb_decoder #(
  parameter  int WIN        = 16,
  parameter  int MAX_PREFIX = 31,
  localparam int OW         = MAX_PREFIX + 1,
  localparam int CW         = $clog2(MAX_PREFIX + WIN + 1),
  localparam int AW         = $clog2(WIN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [WIN-1:0] win,
  input  logic          win_valid,
  output logic          adv_valid,
  output logic [AW-1:0] adv_len,
  output logic          busy,
  output logic          result_valid,
  output logic [OW-1:0] result,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFIX,
    S_SUFFIX,
    S_TE,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    M_UE     = 2'b00,
    M_SE     = 2'b01,
    M_TE     = 2'b10,
    M_UE_ALT = 2'b11
  } mode_t;

  localparam logic [CW-1:0] WIN_CW = CW'(WIN);
  localparam logic [CW-1:0] MAX_CW = CW'(MAX_PREFIX);

  state_t        state, state_next;
  mode_t         mode_q, mode_next;
  logic [CW-1:0] lz, lz_next;
  logic [CW-1:0] rem, rem_next;
  logic [OW-1:0] sfx, sfx_next;

  // Prefix scan helpers
  logic          win_zero;
  logic [AW-1:0] lead_pos;
  logic [CW-1:0] lz_plus_lead;
  logic [CW-1:0] lz_plus_win;

  // Suffix chunk helpers
  logic [AW-1:0] sfx_len;
  logic [OW-1:0] sfx_bits;
  logic [OW-1:0] sfx_shift;

  // Result helper
  logic [OW-1:0] k;

  // State register; every decode field is cleared by reset.
  // NOTE: sequential state uses non-blocking assignments so all flops see
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      mode_q <= M_UE;
      lz     <= '0;
      rem    <= '0;
      sfx    <= '0;
    end else begin
      state  <= state_next;
      mode_q <= mode_next;
      lz     <= lz_next;
      rem    <= rem_next;
      sfx    <= sfx_next;
    end
  end

  // Leading-one priority encode: position counted from win[WIN-1].
  always_comb begin
    win_zero = (win == '0);
    lead_pos = '0;
    // The highest set bit is visited last, so it wins.
    for (int i = 0; i < WIN; i++) begin
      if (win[i]) lead_pos = AW'(WIN - 1 - i);
    end
    lz_plus_lead = lz + CW'(lead_pos);
    lz_plus_win  = lz + WIN_CW;
  end

  // Suffix chunk: take min(rem, WIN) bits from the top of the window.
  always_comb begin
    sfx_len   = (rem >= WIN_CW) ? AW'(WIN) : AW'(rem);
    sfx_bits  = OW'(win >> (AW'(WIN) - sfx_len));
    sfx_shift = sfx << sfx_len;
  end

  // Next-state, advance and error logic.
  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    mode_next  = mode_q;
    lz_next    = lz;
    rem_next   = rem;
    sfx_next   = sfx;
    adv_valid  = 1'b0;
    adv_len    = '0;
    err        = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          mode_next = mode_t'(mode);
          lz_next   = '0;
          sfx_next  = '0;
          rem_next  = '0;
          state_next = (mode_t'(mode) == M_TE) ? S_TE : S_PREFIX;
        end
      end

      S_PREFIX: begin
        if (win_valid) begin
          if (win_zero) begin
            if (lz_plus_win <= MAX_CW) begin
              adv_valid = 1'b1;
              adv_len   = AW'(WIN);
              lz_next   = lz_plus_win;
            end else begin
              err        = 1'b1;
              state_next = S_IDLE;
            end
          end else if (lz_plus_lead > MAX_CW) begin
            err        = 1'b1;
            state_next = S_IDLE;
          end else begin
            adv_valid = 1'b1;
            adv_len   = lead_pos + AW'(1);
            lz_next   = lz_plus_lead;
            rem_next  = lz_plus_lead;
            state_next = (lz_plus_lead == '0) ? S_DONE : S_SUFFIX;
          end
        end
      end

      S_SUFFIX: begin
        if (win_valid) begin
          adv_valid = 1'b1;
          adv_len   = sfx_len;
          sfx_next  = sfx_shift | sfx_bits;
          rem_next  = rem - CW'(sfx_len);
          if (rem == CW'(sfx_len)) state_next = S_DONE;
        end
      end

      S_TE: begin
        if (win_valid) begin
          adv_valid  = 1'b1;
          adv_len    = AW'(1);
          sfx_next   = {{(OW-1){1'b0}}, ~win[WIN-1]};
          state_next = S_DONE;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Result mapping; result is driven only while in DONE.
  always_comb begin
    k            = (OW'(1) << lz) - OW'(1) + sfx;
    result       = '0;
    result_valid = (state == S_DONE);
    busy         = (state != S_IDLE);
    if (state == S_DONE) begin
      case (mode_q)
        M_SE:    result = k[0] ? ((k + OW'(1)) >> 1) : (OW'(0) - (k >> 1));
        M_TE:    result = sfx;
        default: result = k;
      endcase
    end
  end

endmodule
